fifo_rd_packer: RTL and testbench

Read-side consumer of the async FIFO, running in the read clock domain. It pops DATA_W-bit words from the FIFO whenever the FIFO is non-empty and space exists, and packs PACK consecutive words into one OUT_W-bit word. The packed word is offered downstream on a valid/ready handshake. It is the reader that sits opposite the FIFO's writer.

---
 rtl/fifo_rd_pkg.sv | 9 +
 rtl/fifo_rd_outreg.sv | 28 ++
 rtl/fifo_rd_packer.sv | 72 +++++++
 tb/tb_fifo_rd_packer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared defaults, packer state encoding and count-width helper
package fifo_rd_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int PACK_DEF = 4;
  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/fifo_rd_outreg.sv
// fifo_rd_outreg: output holding register, stable while valid && !ready
module fifo_rd_outreg #(
  parameter int OUT_W = 16,
  parameter int NW_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic [NW_W-1:0]  load_nwords,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic [NW_W-1:0]  out_nwords,
  output logic             can_load
);
  assign can_load = !out_valid || out_ready;
  always_ff @(posedge clk)
    if (!reset) begin
      out_data <= '0;
      out_valid <= 1'b0;
      out_nwords <= '0;
    end else if (load) begin
      out_data <= load_data;
      out_valid <= 1'b1;
      out_nwords <= load_nwords;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: packs PACK FIFO words per output word; define FIFO_RD_FLUSH_EN to flush idle partial words
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PACK = PACK_DEF,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                           rclk,
  input  logic                           reset,
  input  logic                           fifo_empty,
  output logic                           fifo_rd_en,
  input  logic [DATA_W-1:0]              fifo_data,
  output logic [DATA_W*PACK-1:0]         out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [cnt_w(PACK)-1:0]         out_nwords,
  output logic                           busy
);
  localparam int OUT_W = DATA_W * PACK;
  localparam int CW = cnt_w(PACK);
  localparam logic [CW-1:0] PACK_C = CW'(PACK);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, base_cnt;
  logic inflight, can_load, flush_rdy, xfer;
  logic [OUT_W-1:0] pack, pack_nx;
  always_comb begin
    fifo_rd_en = reset && !fifo_empty && (int'(cnt) + int'(inflight)) < PACK;
    xfer = can_load && (state == FULL || flush_rdy);
    base_cnt = xfer ? '0 : cnt;
    pack_nx = xfer ? '0 : pack;
    if (inflight) pack_nx[int'(base_cnt)*DATA_W +: DATA_W] = fifo_data;
    cnt_nx = base_cnt + CW'(inflight);
    state_nx = cnt_nx == PACK_C ? FULL : (cnt_nx == '0 && !fifo_rd_en) ? IDLE : FILL;
  end
  always_ff @(posedge rclk)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      inflight <= 1'b0;
      pack <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      inflight <= fifo_rd_en;
      pack <= pack_nx;
    end
`ifdef FIFO_RD_FLUSH_EN
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  logic [FW-1:0] fl_cnt;
  assign flush_rdy = fl_cnt == FW'(FLUSH_CYCLES);
  // starved partial word: FILL with nothing in flight means 0 < cnt < PACK
  always_ff @(posedge rclk)
    if (!reset || inflight || xfer) fl_cnt <= '0;
    else if (state == FILL && fifo_empty && !flush_rdy) fl_cnt <= fl_cnt + FW'(1);
`else
  assign flush_rdy = 1'b0;
`endif
  assign busy = state != IDLE || out_valid;
  fifo_rd_outreg #(.OUT_W(OUT_W), .NW_W(CW)) u_outreg (
    .clk(rclk),
    .reset(reset),
    .load(xfer),
    .load_data(pack),
    .load_nwords(cnt),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_nwords(out_nwords),
    .can_load(can_load)
  );
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: FIFO model, scoreboard of expected packed words, table and corner sequences
module tb_fifo_rd_packer;
  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  nw;
  } exp_t;
  typedef struct {
    logic [15:0] nib;
    bit          tog;
    int          rmode;
    logic [15:0] exp_d;
    logic [2:0]  exp_nw;
  } vec_t;
  logic rclk = 1'b0;
  logic reset = 1'b0;
  logic fifo_empty = 1'b1;
  logic fifo_rd_en;
  logic [3:0] fifo_data = '0;
  logic [15:0] out_data;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [2:0] out_nwords;
  logic busy;
  logic [3:0] fq[$];
  exp_t exp_q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int rmode = 1;
  bit tog = 1'b0;
  bit blk = 1'b0;
  bit held_v = 1'b0;
  logic [15:0] held_d;
  logic [2:0] held_n;
  vec_t vt[6];

  fifo_rd_packer dut (
    .rclk(rclk),
    .reset(reset),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_nwords(out_nwords),
    .busy(busy)
  );

  always #5 rclk = ~rclk;

  always @(posedge rclk) begin
    if (fifo_rd_en && !fifo_empty) fifo_data <= fq.pop_front();
    blk <= tog ? !blk : 1'b0;
  end

  always @(posedge rclk) begin
    #2;
    fifo_empty = (fq.size() == 0) || blk;
  end

  always @(posedge rclk) begin
    #3;
    out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
  end

  always @(negedge rclk) begin
    if (!reset) held_v = 1'b0;
    else begin
      if (fifo_rd_en) begin
        checks++;
        if (fifo_empty) begin
          errors++;
          $display("FAIL rd_en_empty: fifo_rd_en=1 while fifo_empty=1, required 0");
        end
      end
      if (held_v) begin
        checks++;
        if (!out_valid || out_data !== held_d || out_nwords !== held_n) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h nw=%0d, required valid=1 data=%h nw=%0d", out_valid, out_data, out_nwords, held_d, held_n);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h nw=%0d, required no word", out_data, out_nwords);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_nwords !== e.nw) begin
            errors++;
            $display("FAIL word: got %h nw=%0d, required %h nw=%0d", out_data, out_nwords, e.d, e.nw);
          end
        end
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_n = out_nwords;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, expv);
    end
  endtask

  task automatic push_nibs(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) fq.push_back(w[i*4 +: 4]);
  endtask

  task automatic set_ready(input int m);
    rmode = m;
    @(posedge rclk);
    #4;
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0) && n < maxc) begin
      @(posedge rclk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words and %0d nibbles pending, required 0", exp_q.size(), fq.size());
    end
    repeat (2) @(posedge rclk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(posedge rclk);
    #1;
    reset = 1'b0;
    repeat (n) @(posedge rclk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    vt[0] = '{16'h3210, 1'b0, 1, 16'h3210, 3'd4};
    vt[1] = '{16'hDCBA, 1'b1, 1, 16'hDCBA, 3'd4};
    vt[2] = '{16'hF00F, 1'b0, 2, 16'hF00F, 3'd4};
    vt[3] = '{16'h1234, 1'b1, 2, 16'h1234, 3'd4};
    vt[4] = '{16'hFFFF, 1'b0, 1, 16'hFFFF, 3'd4};
    vt[5] = '{16'h8E71, 1'b1, 2, 16'h8E71, 3'd4};
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_nwords", 32'(out_nwords), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'h0);
    @(posedge rclk);
    #1;
    reset = 1'b1;
    // basic pack: four consecutive pops then one valid cycle
    push_nibs(16'h3210, 4);
    exp_q.push_back('{16'h3210, 3'd4});
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      chk($sformatf("basic_rd_en_%0d", i), 32'(fifo_rd_en), (i < 4) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge rclk);
    chk("basic_valid", 32'(out_valid), 32'h1);
    @(negedge rclk);
    chk("basic_valid_drop", 32'(out_valid), 32'h0);
    wait_drain(40);
    chk("basic_idle_busy", 32'(busy), 32'h0);
    // table-driven words, some with toggling empty and random ready
    foreach (vt[k]) begin
      tog = vt[k].tog;
      set_ready(vt[k].rmode);
      push_nibs(vt[k].nib, 4);
      exp_q.push_back('{vt[k].exp_d, vt[k].exp_nw});
      wait_drain(100);
      tog = 1'b0;
    end
    set_ready(1);
    // backpressure
    set_ready(0);
    push_nibs(16'h3210, 4);
    push_nibs(16'h7654, 4);
    exp_q.push_back('{16'h3210, 3'd4});
    exp_q.push_back('{16'h7654, 3'd4});
    repeat (20) @(posedge rclk);
    @(negedge rclk);
    chk("bp_valid", 32'(out_valid), 32'h1);
    chk("bp_data", 32'(out_data), 32'h3210);
    chk("bp_rd_en_full", 32'(fifo_rd_en), 32'h0);
    chk("bp_busy", 32'(busy), 32'h1);
    chk("bp_fifo_drained", fq.size(), 32'h0);
    set_ready(1);
    @(negedge rclk);
    chk("bp_first", {15'h0, out_valid, out_data}, {15'h0, 1'b1, 16'h3210});
    @(negedge rclk);
    chk("bp_second", {15'h0, out_valid, out_data}, {15'h0, 1'b1, 16'h7654});
    wait_drain(40);
    // reset mid-fill discards the partial word
    push_nibs(16'h0087, 2);
    repeat (5) @(posedge rclk);
    #1;
    reset = 1'b0;
    @(posedge rclk);
    @(negedge rclk);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_data", 32'(out_data), 32'h0);
    chk("mid_rst_nwords", 32'(out_nwords), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'h0);
    @(posedge rclk);
    #1;
    reset = 1'b1;
    push_nibs(16'hDCB4, 4);
    exp_q.push_back('{16'hDCB4, 3'd4});
    wait_drain(40);
    // partial word with the FIFO starved
    push_nibs(16'h00A9, 2);
`ifdef FIFO_RD_FLUSH_EN
    exp_q.push_back('{16'h00A9, 3'd2});
    wait_drain(60);
    chk("flush_busy", 32'(busy), 32'h0);
`else
    repeat (30) @(posedge rclk);
    @(negedge rclk);
    chk("noflush_valid", 32'(out_valid), 32'h0);
    chk("noflush_busy", 32'(busy), 32'h1);
    do_reset(1);
`endif
    // ready rising at every offset, including the last-lane capture cycle
    for (int d = 0; d < 8; d++) begin
      set_ready(0);
      for (int w = 0; w < 3; w++) begin
        logic [15:0] v;
        v = 16'($urandom);
        push_nibs(v, 4);
        exp_q.push_back('{v, 3'd4});
      end
      repeat (d) @(posedge rclk);
      set_ready(1);
      wait_drain(120);
    end
    chk("final_busy", 32'(busy), 32'h0);
    chk("final_valid", 32'(out_valid), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end
endmodule
